// File: rtl/uart_tx_top_pkg.sv
// Shared definitions for the UART transmitter: state encoding, oversample ratio
// and the frame-length helper used to size the bit counter.
package uart_tx_top_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic int frame_length(input int data_width, input int parity_en);
        return data_width + 2 + ((parity_en != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/uart_baudgen.sv
// Fractional baud generator: x16 tick every P or P+1 clocks (fractional carry),
// bit tick on every 16th x16 tick; restartable by a synchronous clear.
module uart_baudgen
    import uart_tx_top_pkg::*;
#(
    parameter int COUNTER_WIDTH = 20
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [15:0] i_divisor,
    input  logic [3:0]  i_fra_adj,
    input  logic        i_clear,
    output logic        o_baud,
    output logic        o_baud_x16
);

    logic [COUNTER_WIDTH-1:0] remain;
    logic [COUNTER_WIDTH-1:0] remain_next;
    logic [COUNTER_WIDTH-1:0] period;
    logic [3:0]               acc;
    logic [3:0]               acc_next;
    logic [4:0]               acc_sum;
    logic [3:0]               tick_cnt;
    logic [3:0]               tick_base;
    logic [3:0]               tick_cnt_next;
    logic                     tick_next;
    logic                     baud_next;

    assign period  = (i_divisor == 16'd0) ? COUNTER_WIDTH'(1) : COUNTER_WIDTH'(i_divisor);
    assign acc_sum = {1'b0, acc} + {1'b0, i_fra_adj};

    // remain counts clocks left in the current interval; zero only right after
    // reset and means "start a fresh interval", the same as a clear.
    always_comb begin
        remain_next = remain - COUNTER_WIDTH'(1);
        acc_next    = acc;
        tick_base   = tick_cnt;
        if (i_clear || remain == '0) begin
            remain_next = period;
            acc_next    = '0;
            tick_base   = '0;
        end else if (remain == COUNTER_WIDTH'(1)) begin
            remain_next = period + COUNTER_WIDTH'(acc_sum[4]);
            acc_next    = acc_sum[3:0];
        end
        tick_next     = (remain_next == COUNTER_WIDTH'(1));
        baud_next     = tick_next && (tick_base == 4'(OVERSAMPLE - 1));
        tick_cnt_next = tick_next ? tick_base + 4'd1 : tick_base;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            remain     <= '0;
            acc        <= '0;
            tick_cnt   <= '0;
            o_baud_x16 <= 1'b0;
            o_baud     <= 1'b0;
        end else begin
            remain     <= remain_next;
            acc        <= acc_next;
            tick_cnt   <= tick_cnt_next;
            o_baud_x16 <= tick_next;
            o_baud     <= baud_next;
        end
    end

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit,
// each bit lasting one o_baud period from the fractional baud generator.
module uart_tx_top
    import uart_tx_top_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int PARITY_EN     = 0,
    parameter int COUNTER_WIDTH = 20
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [15:0]           i_divisor,
    input  logic [3:0]            i_fra_adj,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_valid,
    output logic                  o_busy,
    output logic                  o_TX,
    output logic                  o_baud,
    output logic                  o_baud_x16
);

    localparam int FRAME_LEN = frame_length(DATA_WIDTH, PARITY_EN);
    localparam int BIT_CNT_W = $clog2(FRAME_LEN);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  parity_bit;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  accept;
    logic                  baud;

    // Restarting the divider on accept aligns bit boundaries to the start bit.
    assign accept = (state == ST_IDLE) && i_valid;
    assign o_baud = baud;

    uart_baudgen #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_baudgen (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_divisor  (i_divisor),
        .i_fra_adj  (i_fra_adj),
        .i_clear    (accept),
        .o_baud     (baud),
        .o_baud_x16 (o_baud_x16)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= ST_IDLE;
            o_TX       <= 1'b1;
            o_busy     <= 1'b0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        shift_reg  <= i_din;
                        parity_bit <= ^i_din;
                        bit_cnt    <= '0;
                        o_TX       <= 1'b0;
                        o_busy     <= 1'b1;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud) begin
                        o_TX      <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud) begin
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == LAST_DATA) begin
                            if (PARITY_EN != 0) begin
                                o_TX  <= parity_bit;
                                state <= ST_PARITY;
                            end else begin
                                o_TX  <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            o_TX      <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud) begin
                        o_TX  <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (baud) begin
                        o_TX   <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    o_TX   <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// Self-checking bench for uart_tx_top: expected serial bits are queued when a
// byte is issued and popped as frames are captured from the line.
module tb_uart_tx_top;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic [15:0]   divisor;
    logic [3:0]    fra;
    logic [DW-1:0] din;
    logic          valid, valid_p;
    logic          busy, tx, baud, x16;
    logic          busy_p, tx_p, baud_p, x16_p;

    always #20 clk = ~clk;

    uart_tx_top #(.DATA_WIDTH(DW), .PARITY_EN(0), .COUNTER_WIDTH(20)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_divisor(divisor), .i_fra_adj(fra),
        .i_din(din), .i_valid(valid), .o_busy(busy), .o_TX(tx),
        .o_baud(baud), .o_baud_x16(x16)
    );

    uart_tx_top #(.DATA_WIDTH(DW), .PARITY_EN(1), .COUNTER_WIDTH(20)) dut_par (
        .i_clk(clk), .i_rstn(rstn), .i_divisor(divisor), .i_fra_adj(fra),
        .i_din(din), .i_valid(valid_p), .o_busy(busy_p), .o_TX(tx_p),
        .o_baud(baud_p), .o_baud_x16(x16_p)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;

    logic        exp_q[$];
    logic        cap_bits[$];
    int          cap_baud_t[$];
    int          cap_busy_len;
    logic        cap_tx_end;
    bit          cap_timeout;
    int unsigned cap_start, cap_end;

    always @(posedge clk) cyc <= cyc + 1;

    // Waits for the chosen DUT to be idle, issues one byte and queues its frame.
    task automatic applyStimulus(input logic [DW-1:0] data, input bit par);
        int w;
        w = 0;
        @(negedge clk);
        while ((par ? busy_p : busy) && w < 20000) begin
            @(negedge clk);
            w++;
        end
        din = data;
        if (par) valid_p = 1'b1;
        else     valid   = 1'b1;
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(data[i]);
        if (par) exp_q.push_back(^data);
        exp_q.push_back(1'b1);
        @(posedge clk);
        #1;
        valid   = 1'b0;
        valid_p = 1'b0;
        din     = DW'($urandom);
    endtask

    // Records one frame: mid-bit line samples, o_baud offsets and busy length.
    task automatic capture_frame(input bit par, input int nbits, input int bitlen);
        int c, w, k;
        cap_bits.delete();
        cap_baud_t.delete();
        cap_timeout  = 1'b0;
        cap_busy_len = 0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(par ? busy_p : busy) && w < 20000);
        if (!(par ? busy_p : busy)) begin
            cap_timeout = 1'b1;
            return;
        end
        cap_start = cyc;
        c = 0;
        k = 0;
        while ((par ? busy_p : busy) && c < bitlen * (nbits + 4)) begin
            if (par ? baud_p : baud) cap_baud_t.push_back(c);
            if (k < nbits && c == bitlen / 2 + k * bitlen) begin
                cap_bits.push_back(par ? tx_p : tx);
                k++;
            end
            @(negedge clk);
            c++;
        end
        if (par ? busy_p : busy) cap_timeout = 1'b1;
        cap_busy_len = c;
        cap_end      = cyc;
        cap_tx_end   = par ? tx_p : tx;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({tx, busy, baud, x16} !== 4'b1000) begin
            n_err++;
            $display("[TB] FAIL reset_outputs got %b want 1000", {tx, busy, baud, x16});
        end
        n_vec++;
        if ({tx_p, busy_p, baud_p, x16_p} !== 4'b1000) begin
            n_err++;
            $display("[TB] FAIL reset_outputs_par got %b want 1000", {tx_p, busy_p, baud_p, x16_p});
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({tx, busy} !== 2'b10) begin
            n_err++;
            $display("[TB] FAIL idle_after_reset got %b want 10", {tx, busy});
        end
    endtask

    task automatic test_free_running();
        int xt[$];
        int bt[$];
        int viol;
        viol = 0;
        repeat (40) @(negedge clk);
        for (int c = 0; c < 1800; c++) begin
            @(negedge clk);
            if (x16) xt.push_back(c);
            if (baud) bt.push_back(c);
            if (baud && !x16) viol++;
        end
        n_vec++;
        if (xt.size() < 14) begin
            n_err++;
            $display("[TB] FAIL x16_count got %0d want >=14", xt.size());
        end else begin
            for (int i = 1; i < 13; i++) begin
                int iv, pair;
                iv   = xt[i] - xt[i-1];
                pair = xt[i+1] - xt[i-1];
                n_vec++;
                if (!((iv == 27 || iv == 28) && pair == 55)) begin
                    n_err++;
                    $display("[TB] FAIL x16_interval%0d got %0d (pair %0d) want 27/28 (pair 55)", i, iv, pair);
                end
            end
        end
        n_vec++;
        if (bt.size() < 4) begin
            n_err++;
            $display("[TB] FAIL baud_count got %0d want >=4", bt.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_vec++;
                if (bt[i] - bt[i-1] != 440) begin
                    n_err++;
                    $display("[TB] FAIL baud_period%0d got %0d want 440", i, bt[i] - bt[i-1]);
                end
            end
        end
        n_vec++;
        if (viol != 0) begin
            n_err++;
            $display("[TB] FAIL baud_without_x16 got %0d want 0", viol);
        end
    endtask

    task automatic test_send_a6();
        applyStimulus(8'hA6, 1'b0);
        capture_frame(1'b0, 10, 440);
        n_vec++;
        if (cap_timeout !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL a6_frame_timeout got 1 want 0");
        end
        for (int i = 0; i < 10; i++) begin
            logic e, a;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            a = (i < cap_bits.size()) ? cap_bits[i] : 1'bz;
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("[TB] FAIL a6_bit%0d got %b want %b", i, a, e);
            end
        end
        n_vec++;
        if (cap_busy_len < 4397 || cap_busy_len > 4401) begin
            n_err++;
            $display("[TB] FAIL a6_busy_len got %0d want 4399+-2", cap_busy_len);
        end
        n_vec++;
        if (cap_baud_t.size() != 10) begin
            n_err++;
            $display("[TB] FAIL a6_baud_count got %0d want 10", cap_baud_t.size());
        end
        for (int i = 0; i < cap_baud_t.size(); i++) begin
            int iv;
            iv = (i == 0) ? cap_baud_t[0] + 1 : cap_baud_t[i] - cap_baud_t[i-1];
            n_vec++;
            if (iv < 439 || iv > 441) begin
                n_err++;
                $display("[TB] FAIL a6_bit_period%0d got %0d want 440+-1", i, iv);
            end
        end
        n_vec++;
        if (cap_tx_end !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL a6_tx_after got %b want 1", cap_tx_end);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned prev_end;
        prev_end = 0;
        fork
            begin
                applyStimulus(8'h37, 1'b0);
                applyStimulus(8'h00, 1'b0);
                applyStimulus(8'hFF, 1'b0);
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    capture_frame(1'b0, 10, 440);
                    n_vec++;
                    if (cap_timeout !== 1'b0) begin
                        n_err++;
                        $display("[TB] FAIL b2b%0d_timeout got 1 want 0", f);
                    end
                    if (f > 0) begin
                        n_vec++;
                        if (cap_start - prev_end != 1) begin
                            n_err++;
                            $display("[TB] FAIL b2b%0d_gap got %0d want 1", f, cap_start - prev_end);
                        end
                    end
                    prev_end = cap_end;
                    for (int i = 0; i < 10; i++) begin
                        logic e, a;
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                        a = (i < cap_bits.size()) ? cap_bits[i] : 1'bz;
                        n_vec++;
                        if (a !== e) begin
                            n_err++;
                            $display("[TB] FAIL b2b%0d_bit%0d got %b want %b", f, i, a, e);
                        end
                    end
                    n_vec++;
                    if (cap_busy_len < 4397 || cap_busy_len > 4401) begin
                        n_err++;
                        $display("[TB] FAIL b2b%0d_busy_len got %0d want 4399+-2", f, cap_busy_len);
                    end
                end
            end
        join
    endtask

    task automatic test_parity();
        logic [DW-1:0] pdata[2];
        pdata[0] = 8'h37;
        pdata[1] = 8'h00;
        for (int f = 0; f < 2; f++) begin
            applyStimulus(pdata[f], 1'b1);
            capture_frame(1'b1, 11, 440);
            n_vec++;
            if (cap_timeout !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL par%0d_timeout got 1 want 0", f);
            end
            for (int i = 0; i < 11; i++) begin
                logic e, a;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                a = (i < cap_bits.size()) ? cap_bits[i] : 1'bz;
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("[TB] FAIL par%0d_bit%0d got %b want %b", f, i, a, e);
                end
            end
            n_vec++;
            if (cap_baud_t.size() != 11 || cap_busy_len < 4837 || cap_busy_len > 4841) begin
                n_err++;
                $display("[TB] FAIL par%0d_length got %0d bauds/%0d clks want 11/4839+-2", f, cap_baud_t.size(), cap_busy_len);
            end
        end
    endtask

    task automatic test_midframe_valid();
        int late_busy;
        late_busy = 0;
        applyStimulus(8'h3C, 1'b0);
        fork
            capture_frame(1'b0, 10, 440);
            begin
                repeat (1500) @(negedge clk);
                din   = 8'hFF;
                valid = 1'b1;
                @(posedge clk);
                #1;
                valid = 1'b0;
            end
        join
        for (int i = 0; i < 10; i++) begin
            logic e, a;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            a = (i < cap_bits.size()) ? cap_bits[i] : 1'bz;
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("[TB] FAIL midvalid_bit%0d got %b want %b", i, a, e);
            end
        end
        repeat (50) begin
            @(negedge clk);
            if (busy) late_busy++;
        end
        n_vec++;
        if (late_busy != 0) begin
            n_err++;
            $display("[TB] FAIL midvalid_extra_frame got %0d busy clks want 0", late_busy);
        end
    endtask

    task automatic test_midframe_reset();
        int low_cnt;
        low_cnt = 0;
        applyStimulus(8'h0F, 1'b0);
        repeat (1000) @(negedge clk);
        exp_q.delete();
        rstn = 1'b0;
        #1;
        n_vec++;
        if ({tx, busy, baud, x16} !== 4'b1000) begin
            n_err++;
            $display("[TB] FAIL midreset_async got %b want 1000", {tx, busy, baud, x16});
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (!tx || busy) low_cnt++;
        end
        n_vec++;
        if (low_cnt != 0) begin
            n_err++;
            $display("[TB] FAIL midreset_resumed got %0d active clks want 0", low_cnt);
        end
        applyStimulus(8'h55, 1'b0);
        capture_frame(1'b0, 10, 440);
        n_vec++;
        if (cap_timeout !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL postreset_timeout got 1 want 0");
        end
        for (int i = 0; i < 10; i++) begin
            logic e, a;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            a = (i < cap_bits.size()) ? cap_bits[i] : 1'bz;
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("[TB] FAIL postreset_bit%0d got %b want %b", i, a, e);
            end
        end
    endtask

    task automatic test_divisor_zero();
        int xh, bh;
        xh = 0;
        bh = 0;
        divisor = 16'd0;
        fra     = 4'd0;
        repeat (40) @(negedge clk);
        repeat (64) begin
            @(negedge clk);
            if (x16) xh++;
            if (baud) bh++;
        end
        n_vec++;
        if (xh != 64 || bh != 4) begin
            n_err++;
            $display("[TB] FAIL div0_ticks got x16=%0d baud=%0d want 64/4", xh, bh);
        end
        fra = 4'd8;
        repeat (10) @(negedge clk);
        applyStimulus(8'hC3, 1'b0);
        capture_frame(1'b0, 10, 24);
        n_vec++;
        if (cap_timeout !== 1'b0 || cap_busy_len < 237 || cap_busy_len > 241) begin
            n_err++;
            $display("[TB] FAIL div0_frame got timeout=%0b len=%0d want 0/239+-2", cap_timeout, cap_busy_len);
        end
        for (int i = 0; i < 10; i++) begin
            logic e, a;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            a = (i < cap_bits.size()) ? cap_bits[i] : 1'bz;
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("[TB] FAIL div0_bit%0d got %b want %b", i, a, e);
            end
        end
        divisor = 16'd27;
    endtask

    initial begin
        rstn    = 1'b0;
        divisor = 16'd27;
        fra     = 4'd8;
        din     = '0;
        valid   = 1'b0;
        valid_p = 1'b0;
        $display("[TB] uart_tx_top bench start");
        test_reset();
        test_free_running();
        test_send_a6();
        test_back_to_back();
        test_parity();
        test_midframe_valid();
        test_midframe_reset();
        test_divisor_zero();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3600000;
        $display("[TB] FAIL watchdog expired after %0d clks", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "[TB] watchdog");
    end

endmodule
